// File: rtl/os_inst_sequencer.sv
// os_inst_sequencer: generates the 64-bit core instruction word for output-stationary
// operation. For each input channel it runs SRAM->L0 fill, SRAM->L1 fill and compute.
// After the last channel it runs psum recall and OFIFO->PMEM writeback.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   start        - begin a run (accepted in IDLE only)
//   n_ic         - input channels for this run, latched at start
//   pmem_base    - first PMEM writeback address, latched at start
//   ofifo_valid  - core OFIFO holds a readable word
//   inst         - registered instruction word to core
//   busy         - high from the cycle after start through the DONE cycle
//   done         - one-cycle end-of-run pulse
//
// Optional build macro OS_SEQ_PERF_CNT_EN adds cycle_cnt[31:0] (busy cycles) and
// stall_cnt[15:0] (writeback stall cycles). Both clear on accepted start and saturate.
module os_inst_sequencer #(
    parameter int unsigned ROW     = 8,
    parameter int unsigned COL     = 8,
    parameter int unsigned LEN_KIJ = 9,
    parameter int unsigned MAX_IC  = 8,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned W_BASE  = 576,
    parameter int unsigned ICW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ICW-1:0]    n_ic,
    input  logic [ADDR_W-1:0] pmem_base,
    input  logic              ofifo_valid,
    output logic [63:0]       inst,
    output logic              busy,
    output logic              done
`ifdef OS_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned CMP_LEN = LEN_KIJ + ROW + COL;
    localparam int unsigned CNT_W   = $clog2(CMP_LEN + COL + 2);
    // Idle: both SRAMs disabled/read-only, output-stationary mode bit set.
    localparam logic [63:0] IDLE_WORD = 64'h0000_0011_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_L0_FILL, S_L1_FILL, S_COMPUTE, S_RECALL, S_WRITEBACK, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ICW-1:0]    ic_q, ic_d;
    logic [ICW-1:0]    n_ic_q, n_ic_d;
    logic [ADDR_W-1:0] pmem_base_q, pmem_base_d;
    logic [63:0]       inst_q, inst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              xfer;
    logic              start_acc;
    logic [CNT_W-1:0]  wb_j;
    logic [ADDR_W-1:0] xmem_off;

    // Next-state, counters and next instruction word (word belongs to state_d's cycle).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        ic_d        = ic_q;
        n_ic_d      = n_ic_q;
        pmem_base_d = pmem_base_q;
        xfer        = 1'b0;
        start_acc   = 1'b0;
        wb_j        = '0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    start_acc   = 1'b1;
                    n_ic_d      = n_ic;
                    pmem_base_d = pmem_base;
                    ic_d        = '0;
                    state_d     = (n_ic == '0 || n_ic > ICW'(MAX_IC)) ? S_RECALL : S_L0_FILL;
                end
            end
            S_L0_FILL: begin
                if (cnt_q == CNT_W'(LEN_KIJ)) begin
                    cnt_d   = '0;
                    state_d = S_L1_FILL;
                end
            end
            S_L1_FILL: begin
                if (cnt_q == CNT_W'(LEN_KIJ)) begin
                    cnt_d   = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (cnt_q == CNT_W'(CMP_LEN - 1)) begin
                    cnt_d   = '0;
                    ic_d    = ic_q + ICW'(1);
                    state_d = (ic_q + ICW'(1) < n_ic_q) ? S_L0_FILL : S_RECALL;
                end
            end
            S_RECALL: begin
                // ofifo_valid sampled here decides whether writeback's first cycle transfers.
                state_d = S_WRITEBACK;
                xfer    = ofifo_valid;
                cnt_d   = CNT_W'(xfer);
            end
            S_WRITEBACK: begin
                // cnt_q counts transfers already issued; after COL of them go to DONE.
                if (cnt_q == CNT_W'(COL)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    xfer  = ofifo_valid;
                    wb_j  = cnt_q;
                    cnt_d = cnt_q + CNT_W'(xfer);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        xmem_off = ADDR_W'(ic_d) * ADDR_W'(LEN_KIJ) + ADDR_W'(cnt_d);
        inst_d   = IDLE_WORD;
        case (state_d)
            S_L0_FILL: begin
                if (cnt_d < CNT_W'(LEN_KIJ)) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = xmem_off;
                end
                // SRAM read data lands one cycle after its address.
                inst_d[2] = (cnt_d != '0);
            end
            S_L1_FILL: begin
                if (cnt_d < CNT_W'(LEN_KIJ)) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = ADDR_W'(W_BASE) + xmem_off;
                end
                inst_d[37] = (cnt_d != '0);
            end
            S_COMPUTE: begin
                if (cnt_d < CNT_W'(LEN_KIJ)) begin
                    inst_d[3] = 1'b1;
                    inst_d[1] = 1'b1;
                end
            end
            S_RECALL: begin
                inst_d[38] = 1'b1;
                inst_d[34] = 1'b1;
            end
            S_WRITEBACK: begin
                inst_d[34]    = 1'b1;
                inst_d[30:20] = pmem_base_q + ADDR_W'(COL - 1) - ADDR_W'(wb_j);
                if (xfer) begin
                    inst_d[39] = 1'b1;
                    inst_d[32] = 1'b0;
                    inst_d[31] = 1'b0;
                    inst_d[6]  = 1'b1;
                end
            end
            default: inst_d = IDLE_WORD;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ic_q        <= '0;
            n_ic_q      <= '0;
            pmem_base_q <= '0;
            inst_q      <= IDLE_WORD;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ic_q        <= ic_d;
            n_ic_q      <= n_ic_d;
            pmem_base_q <= pmem_base_d;
            inst_q      <= inst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef OS_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_q, stall_d;

    // Saturating run counters; stall_q marks a writeback cycle without a transfer.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        stall_d     = (state_d == S_WRITEBACK) && !xfer;
        if (start_acc) begin
            cycle_cnt_d = '0;
            stall_cnt_d = '0;
        end else begin
            if (busy_q && cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 32'd1;
            if (stall_q && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
